// File: rtl/collatz_sweep_ctrl.sv
// Sweep controller: walks a contiguous seed range through the Collatz orbit core
// and keeps the longest orbit seen, the seed count and a saturation flag.
module collatz_sweep_ctrl #(
    parameter int BITS      = 144,
    parameter int OLEN_BITS = 16,
    parameter int PLEN_BITS = 16,
    parameter int SEED_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEED_BITS-1:0] cfg_start,
    input  logic [SEED_BITS-1:0] cfg_count,
    input  logic                 go,
    input  logic                 abort,
    output logic                 core_load,
    output logic                 core_abort,
    output logic [BITS-1:0]      core_seed,
    input  logic                 core_done,
    input  logic [OLEN_BITS-1:0] core_olen,
    input  logic [PLEN_BITS-1:0] core_prec,
    output logic                 busy,
    output logic                 done,
    output logic [SEED_BITS-1:0] best_seed,
    output logic [OLEN_BITS-1:0] best_len,
    output logic [PLEN_BITS-1:0] best_prec,
    output logic [SEED_BITS-1:0] seeds_done,
    output logic                 sat_flag
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state;
    logic [SEED_BITS-1:0] seed;
    logic [SEED_BITS-1:0] count;
    logic [OLEN_BITS-1:0] olen_q;
    logic [PLEN_BITS-1:0] prec_q;
    logic                 seed_small;
    logic [SEED_BITS-1:0] seeds_next;

    // Seeds 0 and 1 have no orbit to compute; they are recorded without the core.
    assign seed_small = (seed < SEED_BITS'(2));
    assign seeds_next = seeds_done + SEED_BITS'(1);

    assign core_seed  = BITS'(seed);
    assign core_load  = (state == S_LOAD) && !seed_small && !abort;
    assign core_abort = (state == S_WAIT) && abort;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE) && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            seed       <= '0;
            count      <= '0;
            olen_q     <= '0;
            prec_q     <= '0;
            best_seed  <= '0;
            best_len   <= '0;
            best_prec  <= '0;
            seeds_done <= '0;
            sat_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && !abort) begin
                        seed       <= cfg_start;
                        count      <= cfg_count;
                        best_seed  <= '0;
                        best_len   <= '0;
                        best_prec  <= '0;
                        seeds_done <= '0;
                        sat_flag   <= 1'b0;
                        state      <= (cfg_count == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (seed_small) begin
                        olen_q <= '0;
                        prec_q <= '0;
                        state  <= S_RECORD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (core_done) begin
                        olen_q <= core_olen;
                        prec_q <= core_prec;
                        state  <= S_RECORD;
                    end
                end
                S_RECORD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        // Strict compare so the earliest seed keeps a tied length.
                        if (olen_q > best_len) begin
                            best_seed <= seed;
                            best_len  <= olen_q;
                            best_prec <= prec_q;
                        end
                        sat_flag   <= sat_flag | (olen_q == '1);
                        seeds_done <= seeds_next;
                        seed       <= seed + SEED_BITS'(1);
                        state      <= (seeds_next == count) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: behavioural orbit core plus a sweep-level reference model.
module tb_collatz_sweep_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cfg_start, cfg_count;
    logic         go, abort;
    logic         core_load, core_abort;
    logic [143:0] core_seed;
    logic         core_done;
    logic [15:0]  core_olen, core_prec;
    logic         busy, done;
    logic [31:0]  best_seed;
    logic [15:0]  best_len, best_prec;
    logic [31:0]  seeds_done;
    logic         sat_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int cabort_cnt = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] ov_a = 32'd0, ov_b = 32'd0, slow_seed = 32'd0;

    collatz_sweep_ctrl dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_count(cfg_count),
        .go(go), .abort(abort), .core_load(core_load), .core_abort(core_abort),
        .core_seed(core_seed), .core_done(core_done), .core_olen(core_olen),
        .core_prec(core_prec), .busy(busy), .done(done), .best_seed(best_seed),
        .best_len(best_len), .best_prec(best_prec), .seeds_done(seeds_done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Orbit model: step count to reach 1, path record = peak value >> 8 (16 bits kept).
    function automatic void model_seed(input logic [31:0] s, output logic [15:0] ol,
                                       output logic [15:0] pr);
        longint unsigned v, peak;
        int steps;
        ol = 16'd0;
        pr = 16'd0;
        if (s >= 32'd2) begin
            v = 64'(s);
            peak = v;
            steps = 0;
            while (v != 64'd1) begin
                v = v[0] ? 3 * v + 1 : v / 2;
                if (v > peak) peak = v;
                steps++;
            end
            ol = 16'(steps);
            pr = 16'(peak >> 8);
            if (s == ov_a || s == ov_b) ol = 16'hFFFF;
        end
    endfunction

    // Behavioural orbit core with a random compute delay.
    always begin
        logic [15:0] ol, pr;
        logic [31:0] s;
        int d;
        bit aborted;
        @(negedge clk);
        if (core_load && !reset) begin
            s = core_seed[31:0];
            got_q.push_back(s);
            model_seed(s, ol, pr);
            d = (s == slow_seed) ? 50 : int'($urandom_range(1, 4));
            aborted = 1'b0;
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                if (core_abort || reset) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                core_olen = ol;
                core_prec = pr;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                core_olen = $urandom;
                core_prec = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (core_load) load_cnt++;
        if (core_abort) cabort_cnt++;
    end

    task automatic start_go(input logic [31:0] st, input logic [31:0] cnt);
        got_q.delete();
        @(posedge clk); #1;
        cfg_start = st;
        cfg_count = cnt;
        go = 1'b1;
    endtask

    // Runs one sweep, returns negedges from go to done and to the first core_load.
    task automatic run_sweep(input logic [31:0] st, input logic [31:0] cnt,
                             output int lat_done, output int lat_load);
        int n, budget, d0;
        bit seen;
        d0 = done_cnt;
        budget = 10 * int'(cnt) + 30;
        lat_load = -1;
        lat_done = -1;
        seen = 1'b0;
        start_go(st, cnt);
        n = 0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (core_load && lat_load < 0) lat_load = n;
            if (done) begin
                seen = 1'b1;
                lat_done = n;
            end
            if (n == 2) begin
                go = 1'b0;
                cfg_start = $urandom;
                cfg_count = $urandom;
            end
        end
        if (!seen) check("sweep_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_after", 64'(busy), 64'd0);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
    endtask

    // Sweep-level reference: expected launches and final results.
    task automatic check_results(input string tag, input logic [31:0] st, input logic [31:0] cnt);
        logic [31:0] s, bs;
        logic [15:0] ol, pr, bl, bp;
        bit sat;
        exp_q.delete();
        bs = 0; bl = 0; bp = 0; sat = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            s = st + 32'(i);
            model_seed(s, ol, pr);
            if (s >= 32'd2) exp_q.push_back(s);
            if (ol > bl) begin
                bs = s; bl = ol; bp = pr;
            end
            if (ol == 16'hFFFF) sat = 1'b1;
        end
        check({tag, "_nloads"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_seed"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_best_seed"}, 64'(best_seed), 64'(bs));
        check({tag, "_best_len"}, 64'(best_len), 64'(bl));
        check({tag, "_best_prec"}, 64'(best_prec), 64'(bp));
        check({tag, "_seeds_done"}, 64'(seeds_done), 64'(cnt));
        check({tag, "_sat"}, 64'(sat_flag), 64'(sat));
    endtask

    initial begin
        int ld, ll, d0, a0, n;
        logic [31:0] st, cnt;
        reset = 1'b1; go = 1'b0; abort = 1'b0; core_done = 1'b0;
        core_olen = '0; core_prec = '0; cfg_start = '0; cfg_count = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", {best_seed, best_len, best_prec}, 64'd0);
        check("rst_seeds", 64'({seeds_done, sat_flag, done, core_load, core_abort}), 64'd0);
        check("rst_core_seed", 64'(core_seed[63:0]), 64'd0);

        run_sweep(32'd1, 32'd10, ld, ll);
        check_results("s1_10", 32'd1, 32'd10);
        check("s1_10_best_seed_lit", 64'(best_seed), 64'd9);
        check("s1_10_best_len_lit", 64'(best_len), 64'd19);

        run_sweep(32'd27, 32'd1, ld, ll);
        check_results("s27", 32'd27, 32'd1);
        check("s27_len_lit", 64'(best_len), 64'd111);
        check("s27_prec_lit", 64'(best_prec), 64'(9232 >> 8));
        check("s27_load_lat", 64'(ll), 64'd2);

        a0 = load_cnt;
        run_sweep(32'd50, 32'd0, ld, ll);
        check("c0_done_lat", 64'(ld), 64'd2);
        check("c0_no_load", 64'(load_cnt - a0), 64'd0);
        check_results("c0", 32'd50, 32'd0);

        run_sweep(32'hFFFFFFFE, 32'd4, ld, ll);
        check_results("wrap", 32'hFFFFFFFE, 32'd4);

        ov_a = 32'd5; ov_b = 32'd7;
        run_sweep(32'd3, 32'd6, ld, ll);
        check_results("sat", 32'd3, 32'd6);
        check("sat_best_seed_lit", 64'(best_seed), 64'd5);
        ov_a = 32'd0; ov_b = 32'd0;

        for (int k = 0; k < 5; k++) begin
            st = $urandom_range(0, 3000);
            cnt = $urandom_range(0, 12);
            run_sweep(st, cnt, ld, ll);
            check_results("rand", st, cnt);
        end

        // Abort three cycles into the second seed's wait.
        slow_seed = 32'd21; d0 = done_cnt; a0 = cabort_cnt;
        start_go(32'd20, 32'd5);
        @(posedge clk); #1 go = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_2nd", 64'(got_q.size()), 64'd2);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_core_abort", 64'(core_abort), 64'd1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_seeds", 64'(seeds_done), 64'd1);
        check("abort_pulses", 64'(cabort_cnt - a0), 64'd1);
        repeat (5) @(posedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        slow_seed = 32'd0;

        // Reset mid-sweep: immediate idle, cleared results, no core abort.
        a0 = cabort_cnt;
        start_go(32'd100, 32'd10);
        @(posedge clk); #1 go = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_outs", 64'({seeds_done, best_len, sat_flag}), 64'd0);
        check("mid_rst_no_cabort", 64'(cabort_cnt - a0), 64'd0);
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
